// File: rtl/mem_wb_stage_elastic_pkg.sv
// Shared types for the elastic MEM->WB stage: default widths, buffer state encoding
// and the packed write-back bundle width.
package mem_wb_stage_elastic_pkg;

    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_PC_W   = 32;
    localparam int unsigned DEF_REG_AW = 5;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_e;

    // pc + we + wbsel + rd + alu + mem
    function automatic int unsigned wbBundleWidth(input int unsigned pcW,
                                                  input int unsigned regAw,
                                                  input int unsigned xlen);
        return pcW + 2 + regAw + 2 * xlen;
    endfunction

endpackage

// File: rtl/mem_wb_stage_elastic_if.sv
// Valid/ready write-back bundle between MEM and WB; master drives the beat, slave returns ready.
interface mem_wb_stage_elastic_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic              we;
    logic              wbsel;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   mem;

    modport master (output valid, output pc, output we, output wbsel, output rd,
                    output alu, output mem, input ready);
    modport slave  (input valid, input pc, input we, input wbsel, input rd,
                    input alu, input mem, output ready);
endinterface

// File: rtl/mem_wb_stage_elastic_pipe_skid_buf.sv
// Generic valid/ready buffer: 2-entry skid with registered inReady (SKID=1) or a
// single register with combinational ready (SKID=0); flush empties it on the next edge.
module mem_wb_stage_elastic_pipe_skid_buf
    import mem_wb_stage_elastic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       occ
);

    bufState_e        stateQ, stateD;
    logic [WIDTH-1:0] mainQ, mainD;
    logic [WIDTH-1:0] skidQ, skidD;
    logic             inReadyQ, inReadyD;
    logic             accept, consume;

    // Skid build breaks the out_ready->in_ready path; plain build forwards it.
    assign inReady  = (SKID != 0) ? inReadyQ : ((stateQ == EMPTY) | outReady);
    assign outValid = (stateQ != EMPTY);
    assign outData  = mainQ;
    assign occ      = 2'(stateQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= EMPTY;
            mainQ    <= '0;
            skidQ    <= '0;
            inReadyQ <= 1'b1;
        end else begin
            stateQ   <= stateD;
            mainQ    <= mainD;
            skidQ    <= skidD;
            inReadyQ <= inReadyD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        mainD   = mainQ;
        skidD   = skidQ;
        accept  = inValid & inReady;
        consume = (stateQ != EMPTY) & outReady;

        case (stateQ)
            EMPTY: begin
                if (accept) begin
                    mainD  = inData;
                    stateD = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    mainD = inData;
                end else if (accept) begin
                    // Only reachable with SKID=1: plain build cannot accept while stalled.
                    skidD  = inData;
                    stateD = TWO;
                end else if (consume) begin
                    stateD = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    mainD  = skidQ;
                    stateD = ONE;
                end
            end
            default: stateD = EMPTY;
        endcase

        // Flush wins over everything; a same-cycle consume has already counted downstream.
        if (flush) begin
            stateD = EMPTY;
        end

        inReadyD = (stateD != TWO);
    end

endmodule

// File: rtl/mem_wb_stage_elastic.sv
// Elastic MEM->WB pipeline stage: packs the write-back bundle through a skid buffer
// and masks the register write enable whenever the output is a bubble.
module mem_wb_stage_elastic
    import mem_wb_stage_elastic_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned PC_W   = DEF_PC_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned SKID   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    mem_wb_stage_elastic_if.slave  inBus,
    mem_wb_stage_elastic_if.master outBus,
    output logic [1:0]             occ
);

    localparam int unsigned WIDTH = wbBundleWidth(PC_W, REG_AW, XLEN);

    logic [WIDTH-1:0] inData;
    logic [WIDTH-1:0] outData;
    logic             mainWe;

    assign inData = {inBus.pc, inBus.we, inBus.wbsel, inBus.rd, inBus.alu, inBus.mem};

    mem_wb_stage_elastic_pipe_skid_buf #(
        .WIDTH (WIDTH),
        .SKID  (SKID)
    ) uBuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inBus.valid),
        .inReady  (inBus.ready),
        .inData   (inData),
        .outValid (outBus.valid),
        .outReady (outBus.ready),
        .outData  (outData),
        .occ      (occ)
    );

    assign {outBus.pc, mainWe, outBus.wbsel, outBus.rd, outBus.alu, outBus.mem} = outData;

    // A bubble must never write the register file.
    assign outBus.we = mainWe & outBus.valid;

endmodule

// File: tb/tb_mem_wb_stage_elastic.sv
// Bench for mem_wb_stage_elastic: SKID=1 and SKID=0 builds driven side by side and
// checked every cycle against per-build FIFO models of accepted beats.
module tb_mem_wb_stage_elastic;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic              wbsel;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   mem;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  flush;
    logic  vValid;
    logic  vOutReady;
    beat_t vIn;
    logic [1:0] occA, occB;

    int checks   = 0;
    int failures = 0;

    // Beats held by each build, oldest first.
    beat_t qA[$];
    beat_t qB[$];

    always #5 clk = ~clk;

    mem_wb_stage_elastic_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW)) inA ();
    mem_wb_stage_elastic_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW)) outA ();
    mem_wb_stage_elastic_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW)) inB ();
    mem_wb_stage_elastic_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW)) outB ();

    assign inA.valid = vValid;   assign inB.valid = vValid;
    assign inA.pc    = vIn.pc;   assign inB.pc    = vIn.pc;
    assign inA.we    = vIn.we;   assign inB.we    = vIn.we;
    assign inA.wbsel = vIn.wbsel; assign inB.wbsel = vIn.wbsel;
    assign inA.rd    = vIn.rd;   assign inB.rd    = vIn.rd;
    assign inA.alu   = vIn.alu;  assign inB.alu   = vIn.alu;
    assign inA.mem   = vIn.mem;  assign inB.mem   = vIn.mem;
    assign outA.ready = vOutReady;
    assign outB.ready = vOutReady;

    mem_wb_stage_elastic #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW), .SKID(1)) dutA (
        .clk(clk), .rst(rst), .flush(flush), .inBus(inA), .outBus(outA), .occ(occA));

    mem_wb_stage_elastic #(.XLEN(XLEN), .PC_W(PC_W), .REG_AW(REG_AW), .SKID(0)) dutB (
        .clk(clk), .rst(rst), .flush(flush), .inBus(inB), .outBus(outB), .occ(occB));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkOne(input string tag, input int sz, input beat_t head,
                            input logic valid, input logic [1:0] occ,
                            input logic [PC_W-1:0] pc, input logic we, input logic wbsel,
                            input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] alu,
                            input logic [XLEN-1:0] mem);
        chk({tag, "_occ"}, 64'(occ), 64'(sz));
        chk({tag, "_out_valid"}, 64'(valid), 64'(sz > 0));
        if (sz > 0) begin
            chk({tag, "_out_pc"}, 64'(pc), 64'(head.pc));
            chk({tag, "_out_we"}, 64'(we), 64'(head.we));
            chk({tag, "_out_wbsel"}, 64'(wbsel), 64'(head.wbsel));
            chk({tag, "_out_rd"}, 64'(rd), 64'(head.rd));
            chk({tag, "_out_alu"}, 64'(alu), 64'(head.alu));
            chk({tag, "_out_mem"}, 64'(mem), 64'(head.mem));
        end else begin
            chk({tag, "_bubble_we"}, 64'(we), 64'(0));
        end
    endtask

    task automatic checkOuts();
        beat_t hA, hB;
        hA = (qA.size() > 0) ? qA[0] : '0;
        hB = (qB.size() > 0) ? qB[0] : '0;
        checkOne("s1", qA.size(), hA, outA.valid, occA, outA.pc, outA.we, outA.wbsel,
                 outA.rd, outA.alu, outA.mem);
        checkOne("s0", qB.size(), hB, outB.valid, occB, outB.pc, outB.we, outB.wbsel,
                 outB.rd, outB.alu, outB.mem);
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic step();
        logic rdyA, rdyB, accA, accB, conA, conB;
        #1;
        rdyA = (qA.size() < 2);
        rdyB = (qB.size() == 0) || vOutReady;
        chk("s1_in_ready", 64'(inA.ready), 64'(rdyA));
        chk("s0_in_ready", 64'(inB.ready), 64'(rdyB));
        accA = vValid && rdyA;
        accB = vValid && rdyB;
        conA = (qA.size() > 0) && vOutReady;
        conB = (qB.size() > 0) && vOutReady;
        @(posedge clk);
        if (flush) begin
            qA.delete();
            qB.delete();
        end else begin
            if (conA) void'(qA.pop_front());
            if (accA) qA.push_back(vIn);
            if (conB) void'(qB.pop_front());
            if (accB) qB.push_back(vIn);
        end
        @(negedge clk);
        checkOuts();
    endtask

    task automatic offer(input logic [PC_W-1:0] pc, input logic we, input logic [REG_AW-1:0] rd,
                         input logic [XLEN-1:0] alu);
        vValid    = 1'b1;
        vIn.pc    = pc;
        vIn.we    = we;
        vIn.wbsel = 1'b0;
        vIn.rd    = rd;
        vIn.alu   = alu;
        vIn.mem   = 32'h0;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_s1_valid"}, 64'(outA.valid), 64'(0));
        chk({tag, "_s1_we"}, 64'(outA.we), 64'(0));
        chk({tag, "_s1_pc"}, 64'(outA.pc), 64'(0));
        chk({tag, "_s1_rd"}, 64'(outA.rd), 64'(0));
        chk({tag, "_s1_alu"}, 64'(outA.alu), 64'(0));
        chk({tag, "_s1_mem"}, 64'(outA.mem), 64'(0));
        chk({tag, "_s1_wbsel"}, 64'(outA.wbsel), 64'(0));
        chk({tag, "_s1_occ"}, 64'(occA), 64'(0));
        chk({tag, "_s1_in_ready"}, 64'(inA.ready), 64'(1));
        chk({tag, "_s0_valid"}, 64'(outB.valid), 64'(0));
        chk({tag, "_s0_pc"}, 64'(outB.pc), 64'(0));
        chk({tag, "_s0_rd"}, 64'(outB.rd), 64'(0));
        chk({tag, "_s0_occ"}, 64'(occB), 64'(0));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; vValid = 1'b0; vOutReady = 1'b0; vIn = '0;

        // Reset then stream
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        vOutReady = 1'b1;
        offer(32'h100, 1'b1, 5'd5, 32'hDEAD);
        step();
        chk("t1_out_pc", 64'(outA.pc), 64'h100);
        chk("t1_out_we", 64'(outA.we), 64'h1);
        chk("t1_out_rd", 64'(outA.rd), 64'd5);
        chk("t1_occ", 64'(occA), 64'd1);
        vValid = 1'b0;
        step();

        // Backpressure fill and ordered drain
        vOutReady = 1'b0;
        offer(32'h100, 1'b1, 5'd1, 32'h1);
        step();
        offer(32'h104, 1'b1, 5'd2, 32'h2);
        step();
        chk("t2_occ_full", 64'(occA), 64'd2);
        offer(32'h108, 1'b1, 5'd3, 32'h3);
        #1;
        chk("t2_in_ready_full", 64'(inA.ready), 64'd0);
        chk("t6_s0_in_ready_stall", 64'(inB.ready), 64'd0);
        chk("t2_head_100", 64'(outA.pc), 64'h100);
        step();
        vOutReady = 1'b1;
        step();
        chk("t2_head_104", 64'(outA.pc), 64'h104);
        step();
        chk("t2_head_108", 64'(outA.pc), 64'h108);
        vValid = 1'b0;
        repeat (2) step();

        // SKID=0: combinational ready follows out_ready
        vOutReady = 1'b0;
        offer(32'h2FC, 1'b0, 5'd4, 32'h4);
        step();
        vOutReady = 1'b1;
        offer(32'h300, 1'b1, 5'd6, 32'h6);
        #1;
        chk("t6_s0_in_ready_comb", 64'(inB.ready), 64'd1);
        step();
        chk("t6_s0_pc_300", 64'(outB.pc), 64'h300);
        chk("t6_s0_occ", 64'(occB), 64'd1);
        vValid = 1'b0;
        step();

        // Flush while full, with a same-cycle offer that must be discarded
        vOutReady = 1'b0;
        offer(32'h180, 1'b1, 5'd8, 32'h8);
        step();
        offer(32'h184, 1'b1, 5'd9, 32'h9);
        step();
        chk("t3_occ_full", 64'(occA), 64'd2);
        flush = 1'b1;
        offer(32'h200, 1'b1, 5'd10, 32'hA);
        step();
        chk("t3_flush_valid", 64'(outA.valid), 64'd0);
        chk("t3_flush_we", 64'(outA.we), 64'd0);
        chk("t3_flush_occ", 64'(occA), 64'd0);
        chk("t3_flush_in_ready", 64'(inA.ready), 64'd1);
        flush = 1'b0;
        vValid = 1'b0;
        vOutReady = 1'b1;
        step();

        // Bubble masking keeps rd but clears we
        vOutReady = 1'b0;
        offer(32'h220, 1'b1, 5'd7, 32'h77);
        step();
        vValid = 1'b0;
        vOutReady = 1'b1;
        step();
        chk("t4_bubble_valid", 64'(outA.valid), 64'd0);
        chk("t4_bubble_we", 64'(outA.we), 64'd0);
        chk("t4_bubble_rd", 64'(outA.rd), 64'd7);
        chk("t4_s0_bubble_rd", 64'(outB.rd), 64'd7);

        // Async reset mid-stream
        vOutReady = 1'b0;
        offer(32'h240, 1'b1, 5'd11, 32'hB);
        step();
        offer(32'h244, 1'b1, 5'd12, 32'hC);
        step();
        chk("t5_occ_full", 64'(occA), 64'd2);
        vValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkAllZero("t5_async");
        qA.delete();
        qB.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vOutReady = 1'b1;
        repeat (2) step();

        // Randomized traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            vValid    = ($urandom_range(0, 9) < 6);
            vOutReady = ($urandom_range(0, 9) < 5);
            flush     = ($urandom_range(0, 29) == 0);
            vIn.pc    = PC_W'($urandom);
            vIn.we    = 1'($urandom);
            vIn.wbsel = 1'($urandom);
            vIn.rd    = REG_AW'($urandom);
            vIn.alu   = XLEN'($urandom);
            vIn.mem   = XLEN'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_elastic.md
Name: mem_wb_stage_elastic

Overview:
Parametrised MEM→WB pipeline stage for the RISC-V core, replacing the fixed always-advance register. It carries the write-back bundle: pc, reg-write enable, write-back select, rd address, ALU result and load data. It adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and bubble masking. It sits between the data-memory stage and the register-file write port.

Parameters:
XLEN, 32, width of ALU result and load data
PC_W, 32, width of pc
REG_AW, 5, register address width
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage offers a beat
in_ready  out  1  stage accepts the beat this cycle
in_pc  in  PC_W  pc of instruction
in_we  in  1  register write enable
in_wbsel  in  1  write-back mux select (0 ALU, 1 load)
in_rd  in  REG_AW  destination register
in_alu  in  XLEN  ALU result
in_mem  in  XLEN  load data
out_valid  out  1  WB beat valid
out_ready  in  1  WB consumes the beat
out_pc, out_we, out_wbsel, out_rd, out_alu, out_mem  out  as inputs  registered bundle
occ  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst low, asynchronous): state EMPTY; all outputs and all internal payload registers, including rd and skid copies, are 0. in_ready is 1 after reset release.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. Latency: 1 cycle from accept to out_valid when the stage was empty.
- Bubble masking: out_we = main_we & out_valid. A non-valid output never writes the register file. Other payload outputs hold their last value and are don't-care when out_valid is 0.
- SKID=1 state machine (occ = 0/1/2):
  - EMPTY: accept → ONE (main ← in); otherwise stay.
  - ONE: accept & consume → ONE (main ← in); accept & !consume → TWO (skid ← in); !accept & consume → EMPTY; neither → hold.
  - TWO: in_ready = 0. Consume → ONE (main ← skid). Otherwise hold.
  - in_ready = (state != TWO), driven from a register. There is no combinational path from out_ready to in_ready.
- SKID=0: single entry. in_ready = !out_valid | out_ready (combinational). Accept loads main; consume without accept clears valid. occ ∈ {0,1}.
- Flush: highest priority, takes effect on the next edge. State → EMPTY, out_valid = 0, occ = 0. A beat accepted in the same cycle is discarded (upstream counts it as accepted-and-killed). Payload registers need not clear.
- Flush and consume in the same cycle: the consume still counts for WB this cycle; the next state is EMPTY.
- Reset asserted mid-operation aborts all state immediately. No beat survives.
- Ordering: beats leave strictly in acceptance order. No drop, no duplicate.

Decomposition:
- Shared Types.v holds `data (XLEN), `regAddr (REG_AW), `instructionAddrPath (PC_W) and the state encoding localparams EMPTY/ONE/TWO.
- Natural sub-module: pipe_skid_buf, a generic valid/ready skid buffer with parameters WIDTH and SKID, plus flush and occ ports.
- mem_wb_stage_elastic packs the fields into WIDTH = PC_W+2+REG_AW+2*XLEN bits, instantiates pipe_skid_buf, and applies we masking on the output.

Test Plan:
1. Reset then stream: rst low 3 cycles → all outputs 0, in_ready=1. Drive in_valid with pc=0x100,we=1,rd=5,alu=0xDEAD and out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_we=1, out_rd=5, occ=1.
2. Backpressure fill (SKID=1): out_ready=0, push pc 0x100 then 0x104 → occ=2, in_ready=0 on the following cycle, 0x108 held off. Raise out_ready → outputs 0x100, 0x104, 0x108 in order, no gaps after in_ready returns.
3. Flush while full: occ=2, assert flush with in_valid=1 (pc=0x200) → next cycle out_valid=0, out_we=0, occ=0, in_ready=1. 0x200 never appears.
4. Bubble masking: accept we=1,rd=7, then consume with in_valid=0 → out_valid=0 and out_we=0 while out_rd still reads 7.
5. Async reset mid-stream: occ=2, drop rst between clock edges → outputs 0 immediately, before any clock edge. After release, in_ready=1 and no stale beat appears.
6. SKID=0 build: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. Raise out_ready with in_valid (pc=0x300) → in_ready=1 combinationally, 0x300 lands next cycle, occ never exceeds 1.
